// File: rtl/part_select_packer.sv
// rtl/part_select_packer.sv - width-up converter packing RATIO narrow beats into one wide word
module part_select_packer #(
  parameter int IN_W  = 2,
  parameter int RATIO = 4,
  parameter int OUT_W = IN_W * RATIO,
  parameter int CNT_W = $clog2(RATIO + 1)
) (
  input  logic             CK,
  input  logic             RN,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] acc_next;
  logic [CNT_W-1:0] held_next;
  logic             accept;
  logic             complete;
  logic             do_flush;
  logic             load;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Slots above cnt are always zero, so acc_next is already the zero-padded partial word.
  always_comb begin
    acc_next  = acc;
    held_next = cnt;
    if (accept) begin
      for (int k = 0; k < RATIO; k++) begin
        if (cnt == CNT_W'(k)) begin
          acc_next[k*IN_W +: IN_W] = in_data;
        end
      end
      held_next = cnt + 1'b1;
    end
  end

  assign complete = accept && (cnt == LAST_SLOT);
  assign do_flush = flush && in_ready && !complete && (held_next != '0);
  assign load     = complete || do_flush;

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      cnt       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
    end else begin
      if (load) begin
        out_data  <= acc_next;
        out_count <= held_next;
        out_valid <= 1'b1;
        cnt       <= '0;
        acc       <= '0;
      end else begin
        if (accept) begin
          acc <= acc_next;
          cnt <= held_next;
        end
        if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_part_select_packer.sv
// tb/tb_part_select_packer.sv - scoreboard bench for part_select_packer (2x4 and 3x5 configurations)
module tb_part_select_packer;

  logic        CK = 1'b0;
  logic        RN = 1'b0;
  always #5 CK = ~CK;

  logic [1:0]  a_in_data = '0;
  logic        a_in_valid = 1'b0, a_flush = 1'b0, a_out_ready = 1'b1;
  logic        a_in_ready, a_out_valid;
  logic [7:0]  a_out_data;
  logic [2:0]  a_out_count;

  logic [2:0]  b_in_data = '0;
  logic        b_in_valid = 1'b0, b_flush = 1'b0, b_out_ready = 1'b1;
  logic        b_in_ready, b_out_valid;
  logic [14:0] b_out_data;
  logic [2:0]  b_out_count;

  part_select_packer #(.IN_W(2), .RATIO(4)) dut_a (
    .CK(CK), .RN(RN), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .flush(a_flush), .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_count(a_out_count)
  );

  part_select_packer #(.IN_W(3), .RATIO(5)) dut_b (
    .CK(CK), .RN(RN), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .flush(b_flush), .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_count(b_out_count)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int stalls_a = 0;
  logic [10:0] exp_a[$];
  logic [17:0] exp_b[$];
  int          pops_a[$];

  always @(posedge CK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitors: pop on every word the consumer actually takes.
  always @(negedge CK) begin
    if (RN && a_out_valid && a_out_ready) begin
      if (exp_a.size() == 0) chk("a_unexpected_word", {21'd0, a_out_count, a_out_data}, 32'hFFFF_FFFF);
      else chk("a_word", {21'd0, a_out_count, a_out_data}, {21'd0, exp_a.pop_front()});
      pops_a.push_back(cyc);
    end
    if (RN && b_out_valid && b_out_ready) begin
      if (exp_b.size() == 0) chk("b_unexpected_word", {14'd0, b_out_count, b_out_data}, 32'hFFFF_FFFF);
      else chk("b_word", {14'd0, b_out_count, b_out_data}, {14'd0, exp_b.pop_front()});
    end
  end

  task automatic send_a(input logic [1:0] d, input logic fl);
    int   guard = 0;
    logic rdy;
    a_in_data = d; a_in_valid = 1'b1; a_flush = fl;
    do begin
      #1 rdy = a_in_ready;
      if (!rdy) stalls_a++;
      @(posedge CK); #1;
      guard++;
    end while (!rdy && guard < 50);
    if (!rdy) chk("a_send_timeout", 32'd0, 32'd1);
    a_in_valid = 1'b0; a_flush = 1'b0;
  endtask

  task automatic send_b(input logic [2:0] d, input logic fl);
    int   guard = 0;
    logic rdy;
    b_in_data = d; b_in_valid = 1'b1; b_flush = fl;
    do begin
      #1 rdy = b_in_ready;
      @(posedge CK); #1;
      guard++;
    end while (!rdy && guard < 50);
    if (!rdy) chk("b_send_timeout", 32'd0, 32'd1);
    b_in_valid = 1'b0; b_flush = 1'b0;
  endtask

  task automatic flush_only_a();
    a_in_valid = 1'b0; a_flush = 1'b1;
    @(posedge CK); #1;
    a_flush = 1'b0;
  endtask

  initial begin
    logic [1:0] w1[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] bb[12] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    int guard;

    // Reset state
    #12;
    chk("rst_a_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_a_out_data", {24'd0, a_out_data}, 32'd0);
    chk("rst_a_out_count", {29'd0, a_out_count}, 32'd0);
    chk("rst_b_out_valid", {31'd0, b_out_valid}, 32'd0);
    RN = 1'b1;
    @(posedge CK); #1;
    chk("rst_a_in_ready", {31'd0, a_in_ready}, 32'd1);

    // Basic word 0x39, in_ready never drops
    stalls_a = 0;
    exp_a.push_back({3'd4, 8'h39});
    foreach (w1[i]) send_a(w1[i], 1'b0);
    chk("basic_valid", {31'd0, a_out_valid}, 32'd1);
    chk("basic_stalls", stalls_a, 32'd0);
    @(posedge CK); #1;

    // Stall: word held, next beat waits for out_ready
    a_out_ready = 1'b0;
    exp_a.push_back({3'd4, 8'h39});
    foreach (w1[i]) send_a(w1[i], 1'b0);
    a_in_data = 2'd2; a_in_valid = 1'b1;
    repeat (5) begin
      #1;
      chk("stall_in_ready", {31'd0, a_in_ready}, 32'd0);
      chk("stall_out_data", {24'd0, a_out_data}, 32'h39);
      @(posedge CK); #1;
    end
    a_out_ready = 1'b1;
    exp_a.push_back({3'd4, 8'h56});
    send_a(2'd2, 1'b0); send_a(2'd1, 1'b0); send_a(2'd1, 1'b0); send_a(2'd1, 1'b0);
    @(posedge CK); #1;

    // Flush alone after 3 beats, then a full word from slot 0
    exp_a.push_back({3'd3, 8'h1B});
    send_a(2'd3, 1'b0); send_a(2'd2, 1'b0); send_a(2'd1, 1'b0);
    flush_only_a();
    exp_a.push_back({3'd4, 8'h39});
    foreach (w1[i]) send_a(w1[i], 1'b0);
    @(posedge CK); #1;

    // Flush with the 2nd beat, then an empty flush yields nothing
    exp_a.push_back({3'd2, 8'h06});
    send_a(2'd2, 1'b0); send_a(2'd1, 1'b1);
    flush_only_a();
    chk("empty_flush_no_valid", {31'd0, a_out_valid}, 32'd0);
    @(posedge CK); #1;

    // 12 back-to-back beats: 3 words, 4 cycles apart
    stalls_a = 0;
    pops_a.delete();
    exp_a.push_back({3'd4, 8'h39});
    exp_a.push_back({3'd4, 8'hE4});
    exp_a.push_back({3'd4, 8'hFF});
    foreach (bb[i]) send_a(bb[i], 1'b0);
    @(posedge CK); #1;
    chk("b2b_stalls", stalls_a, 32'd0);
    chk("b2b_words", pops_a.size(), 32'd3);
    if (pops_a.size() == 3) begin
      chk("b2b_spacing1", pops_a[1] - pops_a[0], 32'd4);
      chk("b2b_spacing2", pops_a[2] - pops_a[1], 32'd4);
    end

    // 3x5 configuration: [k*3 +: 3] mapping, flush and full words
    exp_b.push_back({3'd5, 15'h3547});
    send_b(3'd7, 1'b0); send_b(3'd0, 1'b0); send_b(3'd5, 1'b0); send_b(3'd2, 1'b0); send_b(3'd3, 1'b0);
    exp_b.push_back({3'd2, 15'h0031});
    send_b(3'd1, 1'b0); send_b(3'd6, 1'b1);
    exp_b.push_back({3'd5, 15'h4924});
    repeat (5) send_b(3'd4, 1'b0);
    @(posedge CK); #1;

    // Asynchronous reset after 2 beats
    send_a(2'd3, 1'b0); send_a(2'd3, 1'b0);
    #2 RN = 1'b0;
    #1;
    chk("arst1_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("arst1_out_count", {29'd0, a_out_count}, 32'd0);
    @(posedge CK); #3 RN = 1'b1;

    // Asynchronous reset mid-stall; the stalled word is discarded
    a_out_ready = 1'b0;
    @(posedge CK); #1;
    foreach (w1[i]) send_a(w1[i], 1'b0);
    chk("pre_arst2_valid", {31'd0, a_out_valid}, 32'd1);
    #2 RN = 1'b0;
    #1;
    chk("arst2_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("arst2_out_count", {29'd0, a_out_count}, 32'd0);
    chk("arst2_out_data", {24'd0, a_out_data}, 32'd0);
    a_out_ready = 1'b1;
    @(posedge CK); #3 RN = 1'b1;
    @(posedge CK); #1;
    exp_a.push_back({3'd4, 8'h39});
    foreach (w1[i]) send_a(w1[i], 1'b0);

    guard = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && guard < 100) begin
      @(posedge CK); #1;
      guard++;
    end
    chk("a_queue_drained", exp_a.size(), 32'd0);
    chk("b_queue_drained", exp_b.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
